// File: rtl/rf_pkg.sv
// Shared types for the register-file write-side front end.
package rf_pkg;
   localparam int REG_AW = 5;
   localparam int XLEN   = 32;

   typedef struct packed {
      logic [REG_AW-1:0] rd;
      logic [XLEN-1:0]   data;
   } wb_req_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_STARVE = 2'd2
   } arb_state_e;
endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of wb_req_t with synchronous active-high reset.
// DEPTH must be a power of 2 so pointers wrap naturally.
import rf_pkg::*;

module wb_fifo #(
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  wb_req_t       din,
   output wb_req_t       dout,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);

   wb_req_t       mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          push_ok, pop_ok;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign dout    = mem_q[rd_ptr_q];
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges pipeline writeback (port A) and buffered long-latency results (port B)
// onto the register file write port. Optional macro: WB_BYPASS_EN.
import rf_pkg::*;

module regfile_wb_arbiter #(
   parameter  int XLEN       = rf_pkg::XLEN,
   parameter  int DEPTH      = 4,
   parameter  int STARVE_MAX = 8,
   localparam int CW         = $clog2(DEPTH) + 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            a_valid,
   input  logic [4:0]      a_rd,
   input  logic [XLEN-1:0] a_data,
   input  logic            b_valid,
   output logic            b_ready,
   input  logic [4:0]      b_rd,
   input  logic [XLEN-1:0] b_data,
   output logic            rf_we,
   output logic [4:0]      rf_wa,
   output logic [XLEN-1:0] rf_wd,
   output logic            stall_req,
   output logic [CW-1:0]   fifo_count
);

   localparam int SW = $clog2(STARVE_MAX) + 1;
   localparam logic [SW-1:0] STARVE_THR = SW'(STARVE_MAX - 1);

   wb_req_t         b_req, head;
   logic            fifo_full, fifo_empty, fifo_push, fifo_pop;
   logic            a_win, b_push, bypass;
   logic            rf_we_q, rf_we_d;
   logic [4:0]      rf_wa_q, rf_wa_d;
   logic [XLEN-1:0] rf_wd_q, rf_wd_d;
   logic [SW-1:0]   starve_q, starve_d;
   arb_state_e      state_q, state_d;

   assign b_req.rd   = b_rd;
   assign b_req.data = b_data;

   // x0 writes from A leave the slot free for the FIFO.
   assign a_win   = a_valid && (a_rd != 5'd0);
   assign b_ready = !rst && !fifo_full;
   assign b_push  = b_valid && b_ready;

`ifdef WB_BYPASS_EN
   assign bypass = b_push && fifo_empty && !a_win;
`else
   assign bypass = 1'b0;
`endif

   assign fifo_push = b_push && !bypass;
   assign fifo_pop  = !a_win && !fifo_empty;

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (b_req),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_comb begin
      rf_we_d = 1'b0;
      rf_wa_d = rf_wa_q;
      rf_wd_d = rf_wd_q;
      if (a_win) begin
         rf_we_d = 1'b1;
         rf_wa_d = a_rd;
         rf_wd_d = a_data;
      end else if (fifo_pop) begin
         rf_we_d = (head.rd != 5'd0);
         rf_wa_d = head.rd;
         rf_wd_d = head.data;
      end else if (bypass) begin
         rf_we_d = (b_rd != 5'd0);
         rf_wa_d = b_rd;
         rf_wd_d = b_data;
      end
   end

   always_comb begin
      starve_d = starve_q;
      if (fifo_pop || fifo_empty)
         starve_d = '0;
      else if (a_win && (starve_q < STARVE_THR))
         starve_d = starve_q + SW'(1);
   end

   // A pop leaves the FIFO empty only if it held one entry and nothing arrives.
   always_comb begin
      state_d = state_q;
      if (fifo_pop)
         state_d = ((fifo_count == CW'(1)) && !fifo_push) ? ST_IDLE : ST_DRAIN;
      else if (fifo_push && (state_q == ST_IDLE))
         state_d = ST_DRAIN;
      else if ((state_q == ST_DRAIN) && !fifo_empty && (starve_q >= STARVE_THR))
         state_d = ST_STARVE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rf_we_q  <= 1'b0;
         rf_wa_q  <= '0;
         rf_wd_q  <= '0;
         starve_q <= '0;
         state_q  <= ST_IDLE;
      end else begin
         rf_we_q  <= rf_we_d;
         rf_wa_q  <= rf_wa_d;
         rf_wd_q  <= rf_wd_d;
         starve_q <= starve_d;
         state_q  <= state_d;
      end
   end

   assign rf_we     = rf_we_q;
   assign rf_wa     = rf_wa_q;
   assign rf_wd     = rf_wd_q;
   assign stall_req = (state_q == ST_STARVE);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter; expectations are hand-derived per scenario.
module tb_regfile_wb_arbiter;

   logic        clk, rst;
   logic        a_valid, b_valid, b_ready;
   logic [4:0]  a_rd, b_rd, rf_wa;
   logic [31:0] a_data, b_data, rf_wd;
   logic        rf_we, stall_req;
   logic [2:0]  fifo_count;
   int          checks = 0;
   int          failures = 0;

   regfile_wb_arbiter #(.XLEN(32), .DEPTH(4), .STARVE_MAX(8)) dut (
      .clk(clk), .rst(rst),
      .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data),
      .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
      .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
      .stall_req(stall_req), .fifo_count(fifo_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic idle_inputs();
      a_valid = 0; a_rd = 0; a_data = 0;
      b_valid = 0; b_rd = 0; b_data = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1;
      repeat (2) @(negedge clk);
      checks++; if (rf_we !== 1'b0 || rf_wa !== 5'd0 || rf_wd !== 32'd0) begin failures++; $display("FAIL reset_rf got we=%b wa=%0d wd=%h exp 0/0/0", rf_we, rf_wa, rf_wd); end
      checks++; if (stall_req !== 1'b0 || fifo_count !== 3'd0) begin failures++; $display("FAIL reset_state got stall=%b cnt=%0d exp 0/0", stall_req, fifo_count); end
      checks++; if (b_ready !== 1'b0) begin failures++; $display("FAIL reset_bready_in_rst got %b exp 0", b_ready); end
      rst = 0;
      #1;
      checks++; if (b_ready !== 1'b1) begin failures++; $display("FAIL reset_bready_after got %b exp 1", b_ready); end
      // queue three entries behind a busy A, then reset mid-drain
      a_valid = 1; a_rd = 9; a_data = 32'h9;
      for (int i = 1; i <= 3; i++) begin
         b_valid = 1; b_rd = 5'(i); b_data = 32'(i);
         @(negedge clk);
      end
      checks++; if (fifo_count !== 3'd3) begin failures++; $display("FAIL middrain_count got %0d exp 3", fifo_count); end
      b_valid = 0;
      rst = 1;
      @(negedge clk);
      checks++; if (rf_we !== 1'b0 || fifo_count !== 3'd0 || stall_req !== 1'b0) begin failures++; $display("FAIL middrain_reset got we=%b cnt=%0d stall=%b exp 0/0/0", rf_we, fifo_count, stall_req); end
      rst = 0;
      idle_inputs();
      #1;
      checks++; if (b_ready !== 1'b1) begin failures++; $display("FAIL middrain_bready got %b exp 1", b_ready); end
      @(negedge clk);
      checks++; if (rf_we !== 1'b0 || fifo_count !== 3'd0) begin failures++; $display("FAIL middrain_discard got we=%b cnt=%0d exp 0/0", rf_we, fifo_count); end
   endtask

   task automatic test_a_only();
      a_valid = 1; a_rd = 5; a_data = 32'hDEADBEEF;
      @(negedge clk);
      checks++; if (rf_we !== 1'b1 || rf_wa !== 5'd5 || rf_wd !== 32'hDEADBEEF) begin failures++; $display("FAIL a_only_write got we=%b wa=%0d wd=%h exp 1/5/deadbeef", rf_we, rf_wa, rf_wd); end
      idle_inputs();
      @(negedge clk);
      checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL a_only_pulse got we=%b exp 0", rf_we); end
   endtask

   task automatic test_x0_drop();
      a_valid = 1; a_rd = 9; a_data = 32'h9;
      b_valid = 1; b_rd = 7; b_data = 32'h11;
      @(negedge clk);
      b_rd = 0; b_data = 32'h99;
      @(negedge clk);
      checks++; if (fifo_count !== 3'd2) begin failures++; $display("FAIL x0_fill got cnt=%0d exp 2", fifo_count); end
      b_valid = 0;
      a_rd = 0; a_data = 32'h55;
      @(negedge clk);
      checks++; if (rf_we !== 1'b1 || rf_wa !== 5'd7 || rf_wd !== 32'h11) begin failures++; $display("FAIL x0_a_dropped got we=%b wa=%0d wd=%h exp 1/7/11", rf_we, rf_wa, rf_wd); end
      checks++; if (fifo_count !== 3'd1) begin failures++; $display("FAIL x0_pop1 got cnt=%0d exp 1", fifo_count); end
      a_valid = 0;
      @(negedge clk);
      checks++; if (rf_we !== 1'b0 || fifo_count !== 3'd0) begin failures++; $display("FAIL x0_head_rd0 got we=%b cnt=%0d exp 0/0", rf_we, fifo_count); end
      idle_inputs();
   endtask

   task automatic test_full_fifo();
      a_valid = 1; a_rd = 9; a_data = 32'h9;
      for (int i = 1; i <= 4; i++) begin
         b_valid = 1; b_rd = 5'(i); b_data = 32'h100 + 32'(i);
         #1;
         checks++; if (b_ready !== 1'b1) begin failures++; $display("FAIL full_bready_fill%0d got %b exp 1", i, b_ready); end
         @(negedge clk);
      end
      checks++; if (fifo_count !== 3'd4 || b_ready !== 1'b0) begin failures++; $display("FAIL full_reached got cnt=%0d bready=%b exp 4/0", fifo_count, b_ready); end
      // A goes idle while a new B result waits: full refuses it despite the pop
      a_valid = 0;
      b_valid = 1; b_rd = 15; b_data = 32'h1F;
      #1;
      checks++; if (b_ready !== 1'b0) begin failures++; $display("FAIL full_refuse_on_pop got bready=%b exp 0", b_ready); end
      @(negedge clk);
      checks++; if (rf_we !== 1'b1 || rf_wa !== 5'd1 || rf_wd !== 32'h101 || fifo_count !== 3'd3) begin failures++; $display("FAIL full_drain1 got we=%b wa=%0d wd=%h cnt=%0d exp 1/1/101/3", rf_we, rf_wa, rf_wd, fifo_count); end
      @(negedge clk);
      checks++; if (rf_we !== 1'b1 || rf_wa !== 5'd2 || rf_wd !== 32'h102 || fifo_count !== 3'd3) begin failures++; $display("FAIL full_drain2_pushpop got we=%b wa=%0d wd=%h cnt=%0d exp 1/2/102/3", rf_we, rf_wa, rf_wd, fifo_count); end
      b_valid = 0;
      @(negedge clk);
      checks++; if (rf_we !== 1'b1 || rf_wa !== 5'd3 || rf_wd !== 32'h103 || fifo_count !== 3'd2) begin failures++; $display("FAIL full_drain3 got we=%b wa=%0d wd=%h cnt=%0d exp 1/3/103/2", rf_we, rf_wa, rf_wd, fifo_count); end
      @(negedge clk);
      checks++; if (rf_we !== 1'b1 || rf_wa !== 5'd4 || rf_wd !== 32'h104 || fifo_count !== 3'd1) begin failures++; $display("FAIL full_drain4 got we=%b wa=%0d wd=%h cnt=%0d exp 1/4/104/1", rf_we, rf_wa, rf_wd, fifo_count); end
      @(negedge clk);
      checks++; if (rf_we !== 1'b1 || rf_wa !== 5'd15 || rf_wd !== 32'h1F || fifo_count !== 3'd0) begin failures++; $display("FAIL full_drain_wrapped got we=%b wa=%0d wd=%h cnt=%0d exp 1/15/1f/0", rf_we, rf_wa, rf_wd, fifo_count); end
      @(negedge clk);
      checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL full_drain_done got we=%b exp 0", rf_we); end
      idle_inputs();
   endtask

   task automatic test_starvation();
      a_valid = 1; a_rd = 9; a_data = 32'h9;
      b_valid = 1; b_rd = 10; b_data = 32'hAA;
      @(negedge clk);
      b_valid = 0;
      checks++; if (fifo_count !== 3'd1 || stall_req !== 1'b0) begin failures++; $display("FAIL starve_queued got cnt=%0d stall=%b exp 1/0", fifo_count, stall_req); end
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         checks++; if (stall_req !== 1'b0 || rf_wa !== 5'd9) begin failures++; $display("FAIL starve_wait%0d got stall=%b wa=%0d exp 0/9", k, stall_req, rf_wa); end
      end
      @(negedge clk);
      checks++; if (stall_req !== 1'b1) begin failures++; $display("FAIL starve_raised got stall=%b exp 1", stall_req); end
      a_valid = 0;
      @(negedge clk);
      checks++; if (rf_we !== 1'b1 || rf_wa !== 5'd10 || rf_wd !== 32'hAA) begin failures++; $display("FAIL starve_head_written got we=%b wa=%0d wd=%h exp 1/10/aa", rf_we, rf_wa, rf_wd); end
      @(negedge clk);
      checks++; if (stall_req !== 1'b0 || fifo_count !== 3'd0 || rf_we !== 1'b0) begin failures++; $display("FAIL starve_cleared got stall=%b cnt=%0d we=%b exp 0/0/0", stall_req, fifo_count, rf_we); end
      idle_inputs();
   endtask

   task automatic test_bypass();
      b_valid = 1; b_rd = 3; b_data = 32'h42;
      @(negedge clk);
      b_valid = 0;
`ifdef WB_BYPASS_EN
      checks++; if (rf_we !== 1'b1 || rf_wa !== 5'd3 || rf_wd !== 32'h42 || fifo_count !== 3'd0) begin failures++; $display("FAIL bypass_direct got we=%b wa=%0d wd=%h cnt=%0d exp 1/3/42/0", rf_we, rf_wa, rf_wd, fifo_count); end
      @(negedge clk);
      checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL bypass_pulse got we=%b exp 0", rf_we); end
`else
      checks++; if (rf_we !== 1'b0 || fifo_count !== 3'd1) begin failures++; $display("FAIL nobypass_queued got we=%b cnt=%0d exp 0/1", rf_we, fifo_count); end
      @(negedge clk);
      checks++; if (rf_we !== 1'b1 || rf_wa !== 5'd3 || rf_wd !== 32'h42 || fifo_count !== 3'd0) begin failures++; $display("FAIL nobypass_write got we=%b wa=%0d wd=%h cnt=%0d exp 1/3/42/0", rf_we, rf_wa, rf_wd, fifo_count); end
`endif
      @(negedge clk);
      checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL bypass_settled got we=%b exp 0", rf_we); end
   endtask

   initial begin
      test_reset();
      test_a_only();
      test_x0_drop();
      test_full_fifo();
      test_starvation();
      test_bypass();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
